// File: rtl/axil_reg_arbiter.sv
// Two-requester round-robin arbiter that serialises single-word read/write
// commands onto one AXI4-Lite master port and routes each response back to its owner.
module axil_reg_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic [1:0]                      req_write,
  input  logic [2*C_ADDR_WIDTH-1:0]       req_addr,
  input  logic [2*C_DATA_WIDTH-1:0]       req_wdata,
  input  logic [2*(C_DATA_WIDTH/8)-1:0]   req_wstrb,
  output logic [1:0]                      rsp_valid,
  output logic [C_DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [C_ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_ADDR_WIDTH;
  localparam int DW = C_DATA_WIDTH;
  localparam int SW = C_DATA_WIDTH / 8;
  localparam logic [AW-1:0] ADDR_MASK = ~(AW'(3));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA
  } state_t;

  state_t          state_reg;
  logic            last_grant_reg;
  logic            owner_reg;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   wdata_reg;
  logic [SW-1:0]   wstrb_reg;
  logic            awvalid_reg;
  logic            wvalid_reg;
  logic            arvalid_reg;
  logic            bready_reg;
  logic            rready_reg;
  logic [1:0]      rsp_valid_reg;
  logic [DW-1:0]   rsp_rdata_reg;
  logic [1:0]      rsp_resp_reg;

  logic            grant_next;
  logic            accept;
  logic            aw_done;
  logic            w_done;
  logic [AW-1:0]   addr_arr  [2];
  logic [DW-1:0]   wdata_arr [2];
  logic [SW-1:0]   wstrb_arr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
      assign wstrb_arr[gi] = req_wstrb[gi*SW +: SW];
      assign req_ready[gi] = accept && (grant_next == gi[0]);
    end
  endgenerate

  // With both requesting, the one that did not win last time goes first.
  always_comb begin
    grant_next = 1'b0;
    if (req_valid == 2'b11)
      grant_next = ~last_grant_reg;
    else
      grant_next = req_valid[1];
  end

  // Reset is folded in so the combinational ready stays low while in reset.
  assign accept  = ARESETN && (state_reg == ST_IDLE) && (|req_valid);
  assign aw_done = !awvalid_reg || M_AXI_AWREADY;
  assign w_done  = !wvalid_reg || M_AXI_WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      awvalid_reg    <= 1'b0;
      wvalid_reg     <= 1'b0;
      arvalid_reg    <= 1'b0;
      bready_reg     <= 1'b0;
      rready_reg     <= 1'b0;
      rsp_valid_reg  <= 2'b00;
      rsp_rdata_reg  <= '0;
      rsp_resp_reg   <= 2'b00;
    end else begin
      rsp_valid_reg <= 2'b00;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= 2'b00;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            owner_reg      <= grant_next;
            last_grant_reg <= grant_next;
            addr_reg       <= addr_arr[grant_next] & ADDR_MASK;
            wdata_reg      <= wdata_arr[grant_next];
            wstrb_reg      <= wstrb_arr[grant_next];
            if (req_write[grant_next]) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= ST_WADDR;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= ST_RADDR;
            end
          end
        end
        ST_WADDR: begin
          if (awvalid_reg && M_AXI_AWREADY)
            awvalid_reg <= 1'b0;
          if (wvalid_reg && M_AXI_WREADY)
            wvalid_reg <= 1'b0;
          if (aw_done && w_done) begin
            bready_reg <= 1'b1;
            state_reg  <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (M_AXI_BVALID) begin
            bready_reg    <= 1'b0;
            rsp_valid_reg <= {owner_reg, ~owner_reg};
            rsp_resp_reg  <= M_AXI_BRESP;
            state_reg     <= ST_IDLE;
          end
        end
        ST_RADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (M_AXI_RVALID) begin
            rready_reg    <= 1'b0;
            rsp_valid_reg <= {owner_reg, ~owner_reg};
            rsp_rdata_reg <= M_AXI_RDATA;
            rsp_resp_reg  <= M_AXI_RRESP;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_resp      = rsp_resp_reg;
  assign M_AXI_AWADDR  = addr_reg;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = wstrb_reg;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_BREADY  = bready_reg;
  assign M_AXI_ARADDR  = addr_reg;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Directed bench for axil_reg_arbiter: a small AXI4-Lite register slave model with
// programmable stalls, a response monitor, and hand-computed expectations.
module tb_axil_reg_arbiter;

  localparam int AW = 4;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef struct {
    int          who;
    logic [1:0]  bits;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [1:0]  req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  rsp_valid, rsp_resp;
  logic [31:0] rsp_rdata;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int cyc = 0;
  int checks = 0, passes = 0, fails = 0;
  int aw_delay, b_delay, r_delay;
  logic [1:0] rresp_cfg;

  cmd_t q0[$], q1[$];
  rsp_t rsp_q[$];
  int   grant_q[$], grant_cyc_q[$];
  int   run_base;

  axil_reg_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESETN(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [92:0] all_outs = {req_ready, rsp_valid, rsp_rdata, rsp_resp, awaddr, awprot, awvalid,
                          wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready};

  // ---------------- slave model ----------------
  logic [31:0] mem [4];
  int          aw_wait, b_cnt, r_cnt;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [3:0]  aw_a, w_s;
  logic [31:0] w_d, r_dat;
  logic        aw_hs, w_hs, aw_now, w_now;
  logic [3:0]  a_eff, s_eff;
  logic [31:0] d_eff;

  always_comb begin
    awready = awvalid && (aw_wait >= aw_delay);
    wready  = wvalid;
    arready = arvalid;
    aw_hs   = awvalid && awready;
    w_hs    = wvalid && wready;
    aw_now  = aw_got || aw_hs;
    w_now   = w_got || w_hs;
    a_eff   = aw_hs ? awaddr : aw_a;
    d_eff   = w_hs ? wdata : w_d;
    s_eff   = w_hs ? wstrb : w_s;
    bvalid  = b_pend && (b_cnt == 0);
    bresp   = 2'b00;
    rvalid  = r_pend && (r_cnt == 0);
    rdata   = rvalid ? r_dat : 32'h0;
    rresp   = rvalid ? rresp_cfg : 2'b00;
  end

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      aw_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      b_pend <= 1'b0; b_cnt <= 0; r_pend <= 1'b0; r_cnt <= 0;
      aw_a <= '0; w_d <= '0; w_s <= '0; r_dat <= '0;
      for (int k = 0; k < 4; k++) mem[k] <= 32'h0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      else aw_wait <= 0;
      if (aw_now && w_now) begin
        for (int k = 0; k < 4; k++)
          if (s_eff[k]) mem[a_eff[3:2]][8*k +: 8] <= d_eff[8*k +: 8];
        aw_got <= 1'b0; w_got <= 1'b0;
        b_pend <= 1'b1; b_cnt <= b_delay;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_a <= awaddr; end
        if (w_hs)  begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; end
      end
      if (b_pend && b_cnt != 0) b_cnt <= b_cnt - 1;
      else if (bvalid && bready) b_pend <= 1'b0;
      if (arvalid && arready) begin
        r_pend <= 1'b1; r_cnt <= r_delay; r_dat <= mem[araddr[3:2]];
      end
      if (r_pend && r_cnt != 0) r_cnt <= r_cnt - 1;
      else if (rvalid && rready) r_pend <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int aw_cycles = 0, w_cycles = 0, b_hs = 0, addr_changes = 0, viol = 0;
  int aw_rise = 0, w_rise = 0;
  logic awv_prev = 1'b0, wv_prev = 1'b0;
  logic [3:0] awaddr_prev = '0;

  always @(negedge clk) begin
    if (aresetn) begin
      if (awvalid) aw_cycles <= aw_cycles + 1;
      if (wvalid) w_cycles <= w_cycles + 1;
      if (bvalid && bready) b_hs <= b_hs + 1;
      if (awvalid && !awv_prev) aw_rise <= cyc;
      if (wvalid && !wv_prev) w_rise <= cyc;
      if (awvalid && awv_prev && awaddr != awaddr_prev) addr_changes <= addr_changes + 1;
      if (((awvalid || wvalid) && arvalid) || rsp_valid == 2'b11) viol <= viol + 1;
      if (rsp_valid != 2'b00) begin
        rsp_q.push_back('{int'(rsp_valid[1]), rsp_valid, rsp_rdata, rsp_resp, cyc});
        $display("cyc %0d: rsp to req%0d rdata=0x%08h resp=%0d", cyc, rsp_valid[1], rsp_rdata, rsp_resp);
      end
    end
    awv_prev    <= awvalid;
    wv_prev     <= wvalid;
    awaddr_prev <= awaddr;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d; c.wstrb = s;
    return c;
  endfunction

  task automatic drive_idle();
    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask

  // Present both queues as held requests until all are accepted, then wait for responses.
  task automatic run_cmds();
    int n, budget;
    n = q0.size() + q1.size();
    budget = 0;
    run_base = rsp_q.size();
    grant_q.delete();
    grant_cyc_q.delete();
    while ((q0.size() + q1.size()) > 0 && budget < 300) begin
      @(negedge clk);
      req_valid = {q1.size() > 0, q0.size() > 0};
      req_write = {q1.size() > 0 ? q1[0].wr : 1'b0, q0.size() > 0 ? q0[0].wr : 1'b0};
      req_addr  = {q1.size() > 0 ? q1[0].addr : 4'h0, q0.size() > 0 ? q0[0].addr : 4'h0};
      req_wdata = {q1.size() > 0 ? q1[0].wdata : 32'h0, q0.size() > 0 ? q0[0].wdata : 32'h0};
      req_wstrb = {q1.size() > 0 ? q1[0].wstrb : 4'h0, q0.size() > 0 ? q0[0].wstrb : 4'h0};
      #1;
      if (req_valid[0] && req_ready[0]) begin
        grant_q.push_back(0); grant_cyc_q.push_back(cyc); void'(q0.pop_front());
      end
      if (req_valid[1] && req_ready[1]) begin
        grant_q.push_back(1); grant_cyc_q.push_back(cyc); void'(q1.pop_front());
      end
      budget++;
    end
    @(negedge clk);
    drive_idle();
    chk("all_cmds_accepted", q0.size() + q1.size(), 0);
    q0.delete(); q1.delete();
    budget = 0;
    while (rsp_q.size() < run_base + n && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    #1;
    chk("rsp_count", rsp_q.size() - run_base, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] t3_rdata [8];
  int s_aw, s_w, s_b, s_ac, n_rsp, wait_n;

  initial begin
    aresetn = 1'b0;
    aw_delay = 0; b_delay = 0; r_delay = 0; rresp_cfg = 2'b00;
    drive_idle();
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", all_outs, 0);
    @(negedge clk);
    drive_idle();
    aresetn = 1'b1;

    // T1: single write then read-back, zero-wait slave
    q0.push_back(mk(1'b1, 4'h4, 32'h5, 4'hF));
    run_cmds();
    chk("t1_grant", grant_q[0], 0);
    chk("t1_rsp_bits", rsp_q[run_base].bits, 2'b01);
    chk("t1_wr_resp", rsp_q[run_base].resp, 2'b00);
    chk("t1_wr_rdata", rsp_q[run_base].rdata, 32'h0);
    chk("t1_aw_latency", aw_rise - grant_cyc_q[0], 1);
    chk("t1_w_latency", w_rise - grant_cyc_q[0], 1);
    chk("t1_rsp_latency", rsp_q[run_base].cyc - grant_cyc_q[0], 3);
    q0.push_back(mk(1'b0, 4'h4, 32'h0, 4'h0));
    run_cmds();
    chk("t1_rd_bits", rsp_q[run_base].bits, 2'b01);
    chk("t1_rd_rdata", rsp_q[run_base].rdata, 32'h5);

    // T2: simultaneous requests right after reset
    do_reset();
    q0.push_back(mk(1'b1, 4'h0, 32'hA, 4'hF));
    q1.push_back(mk(1'b1, 4'h8, 32'hB, 4'hF));
    run_cmds();
    chk("t2_first_grant", grant_q[0], 0);
    chk("t2_second_grant", grant_q[1], 1);
    chk("t2_rsp0_bits", rsp_q[run_base].bits, 2'b01);
    chk("t2_rsp1_bits", rsp_q[run_base+1].bits, 2'b10);
    q0.push_back(mk(1'b0, 4'h0, 32'h0, 4'h0));
    q1.push_back(mk(1'b0, 4'h8, 32'h0, 4'h0));
    run_cmds();
    chk("t2_rd0_rdata", rsp_q[run_base].rdata, 32'hA);
    chk("t2_rd0_bits", rsp_q[run_base].bits, 2'b01);
    chk("t2_rd1_rdata", rsp_q[run_base+1].rdata, 32'hB);
    chk("t2_rd1_bits", rsp_q[run_base+1].bits, 2'b10);

    // T3: 4 held commands each, strict alternation; last read uses an unaligned address
    q0.push_back(mk(1'b1, 4'hC, 32'h100, 4'hF));
    q0.push_back(mk(1'b0, 4'hC, 32'h0, 4'h0));
    q0.push_back(mk(1'b1, 4'h4, 32'h200, 4'hF));
    q0.push_back(mk(1'b0, 4'h8, 32'h0, 4'h0));
    q1.push_back(mk(1'b1, 4'h0, 32'h300, 4'hF));
    q1.push_back(mk(1'b0, 4'h0, 32'h0, 4'h0));
    q1.push_back(mk(1'b1, 4'h8, 32'h400, 4'hF));
    q1.push_back(mk(1'b0, 4'h7, 32'h0, 4'h0));
    t3_rdata = '{32'h0, 32'h0, 32'h100, 32'h300, 32'h0, 32'h0, 32'h400, 32'h200};
    run_cmds();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_grant%0d", i), grant_q[i], i % 2);
      chk($sformatf("t3_rsp%0d_bits", i), rsp_q[run_base+i].bits, (i % 2) ? 2'b10 : 2'b01);
      chk($sformatf("t3_rsp%0d_rdata", i), rsp_q[run_base+i].rdata, t3_rdata[i]);
    end
    chk("t3_peak_rate", grant_cyc_q[7] - grant_cyc_q[0], 21);

    // T4: AWREADY stalled 3 cycles, WREADY immediate, partial strobe
    aw_delay = 3;
    s_aw = aw_cycles; s_w = w_cycles; s_b = b_hs; s_ac = addr_changes;
    q1.push_back(mk(1'b1, 4'hC, 32'hDEAD0055, 4'b0011));
    run_cmds();
    chk("t4_single_grant", grant_q[0], 1);
    chk("t4_awvalid_cycles", aw_cycles - s_aw, 4);
    chk("t4_wvalid_cycles", w_cycles - s_w, 1);
    chk("t4_awaddr_stable", addr_changes - s_ac, 0);
    chk("t4_b_handshakes", b_hs - s_b, 1);
    chk("t4_rsp_latency", rsp_q[run_base].cyc - grant_cyc_q[0], 6);
    chk("t4_rsp_bits", rsp_q[run_base].bits, 2'b10);
    aw_delay = 0;
    q1.push_back(mk(1'b0, 4'hC, 32'h0, 4'h0));
    run_cmds();
    chk("t4_readback", rsp_q[run_base].rdata, 32'h00000055);

    // T5: RVALID delayed 5 cycles with SLVERR
    r_delay = 5; rresp_cfg = 2'b10;
    q0.push_back(mk(1'b0, 4'h4, 32'h0, 4'h0));
    run_cmds();
    chk("t5_rsp_resp", rsp_q[run_base].resp, 2'b10);
    chk("t5_rsp_bits", rsp_q[run_base].bits, 2'b01);
    chk("t5_rsp_rdata", rsp_q[run_base].rdata, 32'h200);
    chk("t5_rsp_latency", rsp_q[run_base].cyc - grant_cyc_q[0], 8);
    r_delay = 0; rresp_cfg = 2'b00;

    // T6: reset while waiting for the write response
    b_delay = 3;
    @(negedge clk);
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h00;
    req_wdata = {32'h0, 32'h77}; req_wstrb = 8'h0F;
    #1;
    chk("t6_accept", req_ready, 2'b01);
    @(negedge clk);
    drive_idle();
    wait_n = 0;
    while (!bready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk("t6_in_wresp", bready, 1'b1);
    n_rsp = rsp_q.size();
    #1;
    aresetn = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("t6_reset_outputs", all_outs, 0);
    repeat (4) @(negedge clk);
    chk("t6_no_rsp", rsp_q.size(), n_rsp);
    aresetn = 1'b1;
    #1;
    chk("t6_first_grant", req_ready, 2'b01);
    @(negedge clk);
    drive_idle();
    wait_n = 0;
    while (rsp_q.size() <= n_rsp && wait_n < 30) begin
      @(negedge clk);
      wait_n++;
    end
    #1;
    chk("t6_post_reset_rsp", rsp_q[n_rsp].bits, 2'b01);
    b_delay = 0;

    chk("protocol_invariants", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
